// File: rtl/inst_encoder_loader_if.sv
// Descriptor handshake and instruction-memory write bus for the loader.
interface inst_encoder_loader_if #(
  parameter int unsigned ADDR_W = 10
);
  logic              in_valid;
  logic              in_ready;
  logic [4:0]        in_mnem;
  logic [4:0]        in_rs;
  logic [4:0]        in_rt;
  logic [4:0]        in_rd;
  logic [4:0]        in_shamt;
  logic [15:0]       in_imm;
  logic [25:0]       in_target;
  logic              in_last;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              imem_ack;

  // Host and memory side: drives descriptors and write acknowledges.
  modport master (
    output in_valid, in_mnem, in_rs, in_rt, in_rd, in_shamt, in_imm, in_target, in_last,
    output imem_ack,
    input  in_ready, imem_we, imem_addr, imem_wdata
  );

  // Loader side.
  modport slave (
    input  in_valid, in_mnem, in_rs, in_rt, in_rd, in_shamt, in_imm, in_target, in_last,
    input  imem_ack,
    output in_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/inst_encoder_loader.sv
// Encodes decoded instruction descriptors into MIPS words and writes them
// to instruction memory at sequential word addresses.
module inst_encoder_loader #(
  parameter int unsigned ADDR_W = 10
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  inst_encoder_loader_if.slave       bus,
  output logic [ADDR_W:0]            count,
  output logic                       done,
  output logic                       err_illegal,
  output logic                       err_overflow
);

  localparam int unsigned CNT_W = ADDR_W + 1;

  localparam logic [4:0] MN_SLL     = 5'd3;
  localparam logic [4:0] MN_SRA     = 5'd4;
  localparam logic [4:0] MN_SRL     = 5'd5;
  localparam logic [4:0] MN_JR      = 5'd11;
  localparam logic [4:0] MN_SYSCALL = 5'd12;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t      state;
  logic        last_q;

  logic        legal_c;
  logic        r_type_c;
  logic        j_type_c;
  logic        shift_c;
  logic [5:0]  code_c;
  logic [4:0]  rs_f_c;
  logic [4:0]  rt_f_c;
  logic [4:0]  rd_f_c;
  logic [4:0]  sh_f_c;
  logic [31:0] word_c;

  // Mnemonic decode and field assembly for the incoming descriptor.
  always_comb begin
    legal_c  = 1'b1;
    r_type_c = 1'b0;
    j_type_c = 1'b0;
    code_c   = 6'h00;
    case (bus.in_mnem)
      5'd0:  begin r_type_c = 1'b1; code_c = 6'h20; end // ADD
      5'd1:  begin r_type_c = 1'b1; code_c = 6'h21; end // ADDU
      5'd2:  begin r_type_c = 1'b1; code_c = 6'h24; end // AND
      5'd3:  begin r_type_c = 1'b1; code_c = 6'h00; end // SLL
      5'd4:  begin r_type_c = 1'b1; code_c = 6'h03; end // SRA
      5'd5:  begin r_type_c = 1'b1; code_c = 6'h02; end // SRL
      5'd6:  begin r_type_c = 1'b1; code_c = 6'h22; end // SUB
      5'd7:  begin r_type_c = 1'b1; code_c = 6'h25; end // OR
      5'd8:  begin r_type_c = 1'b1; code_c = 6'h27; end // NOR
      5'd9:  begin r_type_c = 1'b1; code_c = 6'h2A; end // SLT
      5'd10: begin r_type_c = 1'b1; code_c = 6'h2B; end // SLTU
      5'd11: begin r_type_c = 1'b1; code_c = 6'h08; end // JR
      5'd12: begin r_type_c = 1'b1; code_c = 6'h0C; end // SYSCALL
      5'd13: code_c = 6'h08;                             // ADDI
      5'd14: code_c = 6'h09;                             // ADDIU
      5'd15: code_c = 6'h0C;                             // ANDI
      5'd16: code_c = 6'h0D;                             // ORI
      5'd17: code_c = 6'h23;                             // LW
      5'd18: code_c = 6'h2B;                             // SW
      5'd19: code_c = 6'h04;                             // BEQ
      5'd20: code_c = 6'h05;                             // BNE
      5'd21: code_c = 6'h0A;                             // SLTI
      5'd22: begin j_type_c = 1'b1; code_c = 6'h02; end // J
      5'd23: begin j_type_c = 1'b1; code_c = 6'h03; end // JAL
      default: legal_c = 1'b0;
    endcase

    shift_c = (bus.in_mnem == MN_SLL) || (bus.in_mnem == MN_SRA) || (bus.in_mnem == MN_SRL);
    rs_f_c  = bus.in_rs;
    rt_f_c  = bus.in_rt;
    rd_f_c  = bus.in_rd;
    sh_f_c  = 5'd0;
    if (shift_c) begin
      rs_f_c = 5'd0;
      sh_f_c = bus.in_shamt;
    end
    if (bus.in_mnem == MN_JR) begin
      rt_f_c = 5'd0;
      rd_f_c = 5'd0;
    end

    if (r_type_c) begin
      word_c = {6'b000000, rs_f_c, rt_f_c, rd_f_c, sh_f_c, code_c};
    end else if (j_type_c) begin
      word_c = {code_c, bus.in_target};
    end else begin
      word_c = {code_c, bus.in_rs, bus.in_rt, bus.in_imm};
    end
    if (bus.in_mnem == MN_SYSCALL) begin
      word_c = {26'd0, code_c};
    end
  end

  // Load sequencer: accept, hold the write until acked, then finish or continue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      last_q         <= 1'b0;
      bus.in_ready   <= 1'b1;
      bus.imem_we    <= 1'b0;
      bus.imem_addr  <= '0;
      bus.imem_wdata <= '0;
      count          <= '0;
      done           <= 1'b0;
      err_illegal    <= 1'b0;
      err_overflow   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            if (legal_c && !count[ADDR_W]) begin
              bus.imem_wdata <= word_c;
              bus.imem_we    <= 1'b1;
              bus.in_ready   <= 1'b0;
              last_q         <= bus.in_last;
              state          <= WRITE;
            end else begin
              // Skipped descriptor: flag it, but still honour in_last.
              if (!legal_c) begin
                err_illegal <= 1'b1;
              end else begin
                err_overflow <= 1'b1;
              end
              if (bus.in_last) begin
                bus.in_ready <= 1'b0;
                done         <= 1'b1;
                state        <= DONE;
              end
            end
          end
        end
        WRITE: begin
          if (bus.imem_ack) begin
            bus.imem_we   <= 1'b0;
            bus.imem_addr <= bus.imem_addr + ADDR_W'(1);
            if (!count[ADDR_W]) begin
              count <= count + CNT_W'(1);
            end
            if (last_q) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              bus.in_ready <= 1'b1;
              state        <= IDLE;
            end
          end
        end
        DONE: begin
          if (start) begin
            bus.imem_addr <= '0;
            count         <= '0;
            err_illegal   <= 1'b0;
            err_overflow  <= 1'b0;
            done          <= 1'b0;
            bus.in_ready  <= 1'b1;
            state         <= IDLE;
          end
        end
        default: begin
          bus.in_ready <= 1'b1;
          bus.imem_we  <= 1'b0;
          state        <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inst_encoder_loader.sv
// Directed and randomized checks of the instruction encoder/loader.
module tb_inst_encoder_loader;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start_m = 1'b0;
  logic start_s = 1'b0;

  logic [10:0] count_m;
  logic        done_m, ill_m, ovf_m;
  logic [2:0]  count_s;
  logic        done_s, ill_s, ovf_s;

  int vectors = 0;
  int miscompares = 0;

  int exp_addr = 0;
  int exp_count = 0;
  bit exp_ill = 1'b0;

  localparam int RFUNCT [13] = '{32, 33, 36, 0, 3, 2, 34, 37, 39, 42, 43, 8, 12};
  localparam int IOPC   [11] = '{8, 9, 12, 13, 35, 43, 4, 5, 10, 2, 3};

  inst_encoder_loader_if #(.ADDR_W(10)) bm ();
  inst_encoder_loader_if #(.ADDR_W(2))  bs ();

  inst_encoder_loader #(.ADDR_W(10)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start_m), .bus(bm),
    .count(count_m), .done(done_m), .err_illegal(ill_m), .err_overflow(ovf_m)
  );

  inst_encoder_loader #(.ADDR_W(2)) u_small (
    .clk(clk), .rst_n(rst_n), .start(start_s), .bus(bs),
    .count(count_s), .done(done_s), .err_illegal(ill_s), .err_overflow(ovf_s)
  );

  always #5 clk = ~clk;

  // Reference encoding from the instruction-format rules.
  function automatic logic [31:0] model_word(input int m, input int rs, input int rt,
                                             input int rd, input int sh, input int imm,
                                             input int tgt);
    longint unsigned w;
    if (m == 12)                  w = 64'd12;
    else if (m == 11)             w = (longint'(rs) << 21) + 64'd8;
    else if (m >= 3 && m <= 5)    w = (longint'(rt) << 16) + (longint'(rd) << 11) +
                                      (longint'(sh) << 6) + longint'(RFUNCT[m]);
    else if (m <= 10)             w = (longint'(rs) << 21) + (longint'(rt) << 16) +
                                      (longint'(rd) << 11) + longint'(RFUNCT[m]);
    else if (m <= 21)             w = (longint'(IOPC[m-13]) << 26) + (longint'(rs) << 21) +
                                      (longint'(rt) << 16) + longint'(imm);
    else                          w = (longint'(IOPC[m-13]) << 26) + longint'(tgt);
    return 32'(w);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    exp_addr  = 0;
    exp_count = 0;
    exp_ill   = 1'b0;
  endtask

  // One descriptor through the main loader, acting as the memory with a given ack delay.
  task automatic send(input string tag, input int m, input int rs, input int rt, input int rd,
                      input int sh, input int imm, input int tgt, input bit last,
                      input int dly, input logic [31:0] exp_w);
    check({tag, ":ready"}, 32'(bm.in_ready), 32'd1);
    bm.in_valid = 1'b1;  bm.in_mnem = 5'(m);  bm.in_rs = 5'(rs);  bm.in_rt = 5'(rt);
    bm.in_rd = 5'(rd);   bm.in_shamt = 5'(sh); bm.in_imm = 16'(imm);
    bm.in_target = 26'(tgt); bm.in_last = last;
    @(negedge clk);
    bm.in_valid = 1'b0;
    bm.in_last  = 1'b0;
    if (m >= 24) begin
      exp_ill = 1'b1;
      check({tag, ":we_skip"}, 32'(bm.imem_we), 32'd0);
      check({tag, ":err_ill"}, 32'(ill_m), 32'd1);
      check({tag, ":count"}, 32'(count_m), 32'(exp_count));
    end else begin
      check({tag, ":we"}, 32'(bm.imem_we), 32'd1);
      check({tag, ":addr"}, 32'(bm.imem_addr), 32'(exp_addr));
      check({tag, ":wdata"}, bm.imem_wdata, exp_w);
      for (int i = 0; i < dly; i++) begin
        @(negedge clk);
        check({tag, ":hold_we"}, 32'(bm.imem_we), 32'd1);
        check({tag, ":hold_addr"}, 32'(bm.imem_addr), 32'(exp_addr));
        check({tag, ":hold_data"}, bm.imem_wdata, exp_w);
        check({tag, ":hold_rdy"}, 32'(bm.in_ready), 32'd0);
      end
      bm.imem_ack = 1'b1;
      @(negedge clk);
      bm.imem_ack = 1'b0;
      exp_addr  = (exp_addr + 1) % 1024;
      exp_count = exp_count + 1;
      check({tag, ":we_drop"}, 32'(bm.imem_we), 32'd0);
      check({tag, ":count"}, 32'(count_m), 32'(exp_count));
      check({tag, ":next_addr"}, 32'(bm.imem_addr), 32'(exp_addr));
    end
    check({tag, ":done"}, 32'(done_m), 32'(last));
    check({tag, ":rdy_after"}, 32'(bm.in_ready), 32'(!last));
  endtask

  initial begin
    bm.in_valid = 1'b0; bm.in_mnem = '0; bm.in_rs = '0; bm.in_rt = '0; bm.in_rd = '0;
    bm.in_shamt = '0; bm.in_imm = '0; bm.in_target = '0; bm.in_last = 1'b0; bm.imem_ack = 1'b0;
    bs.in_valid = 1'b0; bs.in_mnem = '0; bs.in_rs = '0; bs.in_rt = '0; bs.in_rd = '0;
    bs.in_shamt = '0; bs.in_imm = '0; bs.in_target = '0; bs.in_last = 1'b0; bs.imem_ack = 1'b0;

    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst:ready", 32'(bm.in_ready), 32'd1);
    check("rst:we", 32'(bm.imem_we), 32'd0);
    check("rst:addr", 32'(bm.imem_addr), 32'd0);
    check("rst:wdata", bm.imem_wdata, 32'd0);
    check("rst:count", 32'(count_m), 32'd0);
    check("rst:done", 32'(done_m), 32'd0);
    check("rst:ill", 32'(ill_m), 32'd0);
    check("rst:ovf", 32'(ovf_m), 32'd0);

    // ack outside WRITE is ignored
    bm.imem_ack = 1'b1;
    @(negedge clk);
    bm.imem_ack = 1'b0;
    check("idle_ack:addr", 32'(bm.imem_addr), 32'd0);
    check("idle_ack:count", 32'(count_m), 32'd0);

    send("add", 0, 1, 2, 3, 5, 0, 0, 1'b0, 0, 32'h00221820);

    pulse_reset();
    send("sll", 3, 7, 8, 9, 4, 0, 0, 1'b0, 1, 32'h00084900);
    send("addi", 13, 0, 8, 31, 31, 5, 0, 1'b0, 0, 32'h20080005);

    pulse_reset();
    send("lw", 17, 29, 8, 0, 0, 4, 0, 1'b0, 0, 32'h8FA80004);
    send("beq", 19, 1, 2, 0, 0, 16'hFFFF, 0, 1'b0, 2, 32'h1022FFFF);
    send("j", 22, 0, 0, 0, 0, 0, 26'h0100000, 1'b0, 0, 32'h08100000);
    send("jal", 23, 0, 0, 0, 0, 0, 3, 1'b1, 0, 32'h0C000003);

    // in_valid is ignored once done
    bm.in_valid = 1'b1; bm.in_mnem = 5'd0;
    @(negedge clk);
    bm.in_valid = 1'b0;
    check("done_ign:we", 32'(bm.imem_we), 32'd0);
    check("done_ign:count", 32'(count_m), 32'd4);

    pulse_reset();
    send("syscall", 12, 31, 17, 9, 21, 0, 0, 1'b0, 3, 32'h0000000C);

    // async reset in the middle of a held write
    bm.in_valid = 1'b1; bm.in_mnem = 5'd7; bm.in_rs = 5'd4; bm.in_rt = 5'd5; bm.in_rd = 5'd6;
    @(negedge clk);
    bm.in_valid = 1'b0;
    check("arst:we_pre", 32'(bm.imem_we), 32'd1);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("arst:we", 32'(bm.imem_we), 32'd0);
    check("arst:addr", 32'(bm.imem_addr), 32'd0);
    check("arst:wdata", bm.imem_wdata, 32'd0);
    check("arst:count", 32'(count_m), 32'd0);
    check("arst:ready", 32'(bm.in_ready), 32'd1);
    rst_n = 1'b1;
    exp_addr = 0; exp_count = 0; exp_ill = 1'b0;

    send("illegal27", 27, 1, 2, 3, 0, 0, 0, 1'b0, 0, 32'd0);
    send("or", 7, 1, 2, 3, 9, 0, 0, 1'b0, 0, 32'h00221825);
    check("or:ill_sticky", 32'(ill_m), 32'd1);

    // randomized descriptor stream against the reference model
    pulse_reset();
    for (int k = 0; k < 40; k++) begin
      int m, rs, rt, rd, sh, imm, tgt, dly;
      m   = ($urandom_range(0, 9) == 0) ? int'($urandom_range(24, 31)) : int'($urandom_range(0, 23));
      rs  = int'($urandom_range(0, 31));
      rt  = int'($urandom_range(0, 31));
      rd  = int'($urandom_range(0, 31));
      sh  = int'($urandom_range(0, 31));
      imm = int'($urandom_range(0, 65535));
      tgt = int'($urandom_range(0, 67108863));
      dly = int'($urandom_range(0, 2));
      send("rand", m, rs, rt, rd, sh, imm, tgt, k == 39, dly,
           model_word(m, rs, rt, rd, sh, imm, tgt));
    end
    check("rand:ill", 32'(ill_m), 32'(exp_ill));
    check("rand:ovf", 32'(ovf_m), 32'd0);
    @(negedge clk);
    start_m = 1'b1;
    @(negedge clk);
    start_m = 1'b0;
    check("start:count", 32'(count_m), 32'd0);
    check("start:addr", 32'(bm.imem_addr), 32'd0);
    check("start:ill", 32'(ill_m), 32'd0);
    check("start:done", 32'(done_m), 32'd0);
    check("start:ready", 32'(bm.in_ready), 32'd1);

    // small memory: four writes fill it, the fifth overflows
    for (int k = 0; k < 5; k++) begin
      bs.in_valid = 1'b1; bs.in_mnem = 5'd1; bs.in_rs = 5'(k); bs.in_rt = 5'd2;
      bs.in_rd = 5'd3; bs.in_last = (k == 4);
      @(negedge clk);
      bs.in_valid = 1'b0; bs.in_last = 1'b0;
      if (k < 4) begin
        check("small:we", 32'(bs.imem_we), 32'd1);
        check("small:addr", 32'(bs.imem_addr), 32'(k));
        check("small:wdata", bs.imem_wdata, model_word(1, k, 2, 3, 0, 0, 0));
        bs.imem_ack = 1'b1;
        @(negedge clk);
        bs.imem_ack = 1'b0;
        check("small:count", 32'(count_s), 32'(k + 1));
        check("small:wrap_addr", 32'(bs.imem_addr), 32'((k + 1) % 4));
      end else begin
        check("small:ovf_we", 32'(bs.imem_we), 32'd0);
        check("small:ovf", 32'(ovf_s), 32'd1);
        check("small:ovf_count", 32'(count_s), 32'd4);
        check("small:ovf_done", 32'(done_s), 32'd1);
      end
    end
    start_s = 1'b1;
    @(negedge clk);
    start_s = 1'b0;
    check("small_start:count", 32'(count_s), 32'd0);
    check("small_start:ovf", 32'(ovf_s), 32'd0);
    check("small_start:done", 32'(done_s), 32'd0);
    check("small_start:ready", 32'(bs.in_ready), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
